adder_tree_acc: RTL and testbench

- Parametrised, pipelined, signed adder tree with selectable radix, full-precision width growth, valid tracking and multi-beat accumulation.
- Reduces an INPUT_SIZE-element vector to one sum per beat, then accumulates consecutive beats until in_last, e.g. summing partial products across input channels of a conv layer.
- Sits between the MAC array and the requantise/activation stage.
- Streaming only; no backpressure.

---
 rtl/adder_tree_acc.sv | 302 ++++++++++++++++++++++++++++++
 tb/tb_adder_tree_acc.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_tree_acc.sv
// ---------------------------------------------------------------------------
// adder_tree_acc
//
// Pipelined signed adder tree with multi-beat accumulation. Each valid beat
// of INPUT_SIZE signed elements is reduced to one sum through LEVELS register
// stages (fan-in RADIX per node, full-precision growth). Consecutive tree
// sums are then accumulated until a beat carries last, or until MAX_BEATS
// beats have been summed, at which point the group result is emitted as a
// one-cycle pulse. Streaming only, no backpressure.
//
// Optional build macro: ADDER_TREE_ACC_SAT_EN
//    defined   : when OUT_WIDTH < ACC_W the result is clamped to the signed
//                OUT_WIDTH range and out_sat_o flags the clamp.
//    undefined : the result wraps to its low OUT_WIDTH bits; out_sat_o = 0.
//
// Ports:
//    clk_i          rising-edge clock
//    rst_ni         asynchronous active-low reset
//    flush_i        synchronous clear of valids, accumulator and beat count
//    in_valid_i     beat present this cycle
//    in_last_i      beat closes the current group (qualified by in_valid_i)
//    in_data_i      INPUT_SIZE signed elements of WIDTH bits
//    out_valid_o    one-cycle pulse, group result valid
//    out_data_o     signed group sum, held between pulses
//    out_overrun_o  group force-closed at MAX_BEATS without last
//    out_sat_o      out_data_o was clamped
//
// Group state machine:
//    state   | meaning
//    S_IDLE  | no partial sum held, next tree sum starts a new group
//    S_ACCUM | partial sum of one or more beats held in acc_q
// ---------------------------------------------------------------------------
module adder_tree_acc #(
   parameter int WIDTH      = 17,
   parameter int INPUT_SIZE = 32,
   parameter int RADIX      = 4,
   parameter int MAX_BEATS  = 16,
   parameter int OUT_WIDTH  = WIDTH + $clog2(INPUT_SIZE) + $clog2(MAX_BEATS)
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        flush_i,
   input  logic                        in_valid_i,
   input  logic                        in_last_i,
   input  logic signed [WIDTH-1:0]     in_data_i [INPUT_SIZE],
   output logic                        out_valid_o,
   output logic signed [OUT_WIDTH-1:0] out_data_o,
   output logic                        out_overrun_o,
   output logic                        out_sat_o
);

   function automatic int calc_levels(input int n, input int r);
      int lv;
      int cap;
      lv  = 0;
      cap = 1;
      while (cap < n) begin
         cap = cap * r;
         lv  = lv + 1;
      end
      return lv;
   endfunction

   function automatic int ipow(input int b, input int e);
      int p;
      p = 1;
      for (int i = 0; i < e; i++) begin
         p = p * b;
      end
      return p;
   endfunction

   localparam int LEVELS = calc_levels(INPUT_SIZE, RADIX);
   localparam int LEAVES = ipow(RADIX, LEVELS);
   localparam int TREE_W = WIDTH + $clog2(INPUT_SIZE);
   localparam int ACC_W  = TREE_W + $clog2(MAX_BEATS);
   localparam int CNT_W  = $clog2(MAX_BEATS + 1);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_ACCUM = 1'b1
   } state_t;

   // ------------------------------------------------------------------------
   // Leaves: sign-extended inputs, padding leaves tied to zero
   // ------------------------------------------------------------------------
   logic signed [TREE_W-1:0] leaf [LEAVES];

   for (genvar i = 0; i < LEAVES; i++) begin : g_leaf
      if (i < INPUT_SIZE) begin : g_used
         assign leaf[i] = TREE_W'(in_data_i[i]);
      end else begin : g_pad
         assign leaf[i] = '0;
      end
   end

   // ------------------------------------------------------------------------
   // Tree levels. Every level uses TREE_W, which already holds the full sum
   // of INPUT_SIZE elements, so no node can overflow. Only the first
   // LEAVES/RADIX**(l+1) entries of a level are real nodes.
   // ------------------------------------------------------------------------
   logic signed [TREE_W-1:0] stage_d [LEVELS][LEAVES];
   logic signed [TREE_W-1:0] stage_q [LEVELS][LEAVES];

   for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
      localparam int NODES = LEAVES / ipow(RADIX, l + 1);
      for (genvar n = 0; n < LEAVES; n++) begin : g_node
         if (n < NODES) begin : g_sum
            logic signed [TREE_W-1:0] sum_c;
            if (l == 0) begin : g_from_leaf
               always_comb begin
                  sum_c = '0;
                  for (int k = 0; k < RADIX; k++) begin
                     sum_c = sum_c + leaf[n*RADIX + k];
                  end
               end
            end else begin : g_from_stage
               always_comb begin
                  sum_c = '0;
                  for (int k = 0; k < RADIX; k++) begin
                     sum_c = sum_c + stage_q[l-1][n*RADIX + k];
                  end
               end
            end
            assign stage_d[l][n] = sum_c;
         end else begin : g_idle
            assign stage_d[l][n] = '0;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int l = 0; l < LEVELS; l++) begin
            for (int n = 0; n < LEAVES; n++) begin
               stage_q[l][n] <= '0;
            end
         end
      end else begin
         for (int l = 0; l < LEVELS; l++) begin
            for (int n = 0; n < LEAVES; n++) begin
               stage_q[l][n] <= stage_d[l][n];
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // Valid / last side-band, one bit per tree level
   // ------------------------------------------------------------------------
   logic [LEVELS-1:0] vld_d, vld_q;
   logic [LEVELS-1:0] lst_d, lst_q;

   always_comb begin
      vld_d    = '0;
      lst_d    = '0;
      vld_d[0] = in_valid_i & ~flush_i;
      lst_d[0] = in_last_i & in_valid_i & ~flush_i;
      for (int i = 1; i < LEVELS; i++) begin
         vld_d[i] = vld_q[i-1] & ~flush_i;
         lst_d[i] = lst_q[i-1] & ~flush_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         vld_q <= '0;
         lst_q <= '0;
      end else begin
         vld_q <= vld_d;
         lst_q <= lst_d;
      end
   end

   logic signed [TREE_W-1:0] tree_sum;
   logic                     tree_vld;
   logic                     tree_lst;

   assign tree_sum = stage_q[LEVELS-1][0];
   assign tree_vld = vld_q[LEVELS-1];
   assign tree_lst = lst_q[LEVELS-1];

   // ------------------------------------------------------------------------
   // Accumulate stage
   // ------------------------------------------------------------------------
   state_t                    state_d, state_q;
   logic signed [ACC_W-1:0]   acc_d, acc_q;
   logic [CNT_W-1:0]          cnt_d, cnt_q;
   logic                      out_valid_d, out_valid_q;
   logic signed [OUT_WIDTH-1:0] out_data_d, out_data_q;
   logic                      out_ovr_d, out_ovr_q;
   logic                      out_sat_d, out_sat_q;

   logic signed [ACC_W-1:0]   sum_c;
   logic                      cnt_max;
   logic                      close_c;

   // In S_IDLE the held acc is ignored so the group starts from the tree sum
   assign sum_c   = (state_q == S_IDLE) ? ACC_W'(tree_sum) : acc_q + ACC_W'(tree_sum);
   assign cnt_max = (cnt_q == CNT_W'(MAX_BEATS - 1));
   assign close_c = tree_lst | cnt_max;

   // ------------------------------------------------------------------------
   // Output narrowing ACC_W -> OUT_WIDTH
   // ------------------------------------------------------------------------
   logic signed [OUT_WIDTH-1:0] narrow_data;
   logic                        narrow_sat;

   if (OUT_WIDTH >= ACC_W) begin : g_wide
      assign narrow_data = OUT_WIDTH'(sum_c);
      assign narrow_sat  = 1'b0;
   end else begin : g_narrow
`ifdef ADDER_TREE_ACC_SAT_EN
      localparam logic signed [ACC_W-1:0] POS_LIM =
         {{(ACC_W - OUT_WIDTH + 1){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
      localparam logic signed [ACC_W-1:0] NEG_LIM = ~POS_LIM;

      always_comb begin
         narrow_data = sum_c[OUT_WIDTH-1:0];
         narrow_sat  = 1'b0;
         if (sum_c > POS_LIM) begin
            narrow_data = POS_LIM[OUT_WIDTH-1:0];
            narrow_sat  = 1'b1;
         end else if (sum_c < NEG_LIM) begin
            narrow_data = NEG_LIM[OUT_WIDTH-1:0];
            narrow_sat  = 1'b1;
         end
      end
`else
      assign narrow_data = sum_c[OUT_WIDTH-1:0];
      assign narrow_sat  = 1'b0;
`endif
   end

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      out_valid_d = 1'b0;
      out_data_d  = out_data_q;
      out_ovr_d   = out_ovr_q;
      out_sat_d   = out_sat_q;

      if (flush_i) begin
         state_d    = S_IDLE;
         acc_d      = '0;
         cnt_d      = '0;
         out_data_d = '0;
         out_ovr_d  = 1'b0;
         out_sat_d  = 1'b0;
      end else if (tree_vld) begin
         case (state_q)
            S_IDLE, S_ACCUM: begin
               if (close_c) begin
                  out_valid_d = 1'b1;
                  out_data_d  = narrow_data;
                  out_ovr_d   = ~tree_lst;
                  out_sat_d   = narrow_sat;
                  acc_d       = '0;
                  cnt_d       = '0;
                  state_d     = S_IDLE;
               end else begin
                  acc_d   = sum_c;
                  cnt_d   = cnt_q + CNT_W'(1);
                  state_d = S_ACCUM;
               end
            end
            default: begin
               state_d = S_IDLE;
               acc_d   = '0;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= S_IDLE;
         acc_q       <= '0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_ovr_q   <= 1'b0;
         out_sat_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_ovr_q   <= out_ovr_d;
         out_sat_q   <= out_sat_d;
      end
   end

   assign out_valid_o   = out_valid_q;
   assign out_data_o    = out_data_q;
   assign out_overrun_o = out_ovr_q;
   assign out_sat_o     = out_sat_q;

endmodule

// File: tb/tb_adder_tree_acc.sv
// ---------------------------------------------------------------------------
// Bench for adder_tree_acc. Three instances share one input stream:
//    dut 0 : defaults (RADIX 4, MAX_BEATS 16, full-width output)
//    dut 1 : RADIX 2, MAX_BEATS 4
//    dut 2 : OUT_WIDTH 17 (narrowed output)
// A reference model sums each accepted beat, accumulates groups and queues
// the expected pulse with its due cycle; every cycle every output is checked.
// ---------------------------------------------------------------------------
module tb_adder_tree_acc;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                rst_n;
   logic                flush;
   logic                in_valid;
   logic                in_last;
   logic signed [16:0]  in_data [32];

   logic                va, vb, vc;
   logic signed [25:0]  da;
   logic signed [23:0]  db;
   logic signed [16:0]  dc;
   logic                oa, ob, oc;
   logic                sa, sb, sc;

   adder_tree_acc #(.WIDTH(17), .INPUT_SIZE(32), .RADIX(4), .MAX_BEATS(16)) u_dut_a (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_valid_i(in_valid),
      .in_last_i(in_last), .in_data_i(in_data), .out_valid_o(va),
      .out_data_o(da), .out_overrun_o(oa), .out_sat_o(sa));

   adder_tree_acc #(.WIDTH(17), .INPUT_SIZE(32), .RADIX(2), .MAX_BEATS(4)) u_dut_b (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_valid_i(in_valid),
      .in_last_i(in_last), .in_data_i(in_data), .out_valid_o(vb),
      .out_data_o(db), .out_overrun_o(ob), .out_sat_o(sb));

   adder_tree_acc #(.WIDTH(17), .INPUT_SIZE(32), .RADIX(4), .MAX_BEATS(16),
                    .OUT_WIDTH(17)) u_dut_c (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_valid_i(in_valid),
      .in_last_i(in_last), .in_data_i(in_data), .out_valid_o(vc),
      .out_data_o(dc), .out_overrun_o(oc), .out_sat_o(sc));

   // latency in edges from the sampling edge, group limit, output/acc widths
   localparam int LVL_M [3] = '{3, 5, 3};
   localparam int MB_M  [3] = '{16, 4, 16};
   localparam int OW_M  [3] = '{26, 24, 17};
   localparam int AW_M  [3] = '{26, 24, 26};

   typedef struct {
      int     dut;
      int     due;
      longint data;
      bit     ovr;
      bit     sat;
   } exp_t;

   exp_t   exp_q [$];
   exp_t   log_q [$];
   longint acc_m  [3];
   int     cnt_m  [3];
   longint held_m [3];
   int     cyc;
   int     n_chk;
   int     n_bad;

   task automatic chk(input string tag, input longint act, input longint exp);
      n_chk++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   function automatic longint narrow(input longint v, input int ow, input int aw,
                                     output bit sat);
`ifdef ADDER_TREE_ACC_SAT_EN
      longint lim;
`endif
      sat = 1'b0;
      if (ow >= aw) return v;
`ifdef ADDER_TREE_ACC_SAT_EN
      lim = (longint'(1) <<< (ow - 1)) - 1;
      if (v > lim) begin
         sat = 1'b1;
         return lim;
      end
      if (v < -lim - 1) begin
         sat = 1'b1;
         return -lim - 1;
      end
      return v;
`else
      return (v <<< (64 - ow)) >>> (64 - ow);
`endif
   endfunction

   function automatic longint beat_sum();
      longint s;
      s = 0;
      for (int i = 0; i < 32; i++) s += longint'(in_data[i]);
      return s;
   endfunction

   task automatic model_clear();
      exp_q.delete();
      for (int d = 0; d < 3; d++) begin
         acc_m[d]  = 0;
         cnt_m[d]  = 0;
         held_m[d] = 0;
      end
   endtask

   task automatic model_edge();
      longint s;
      exp_t   e;
      bit     sb_;
      if (flush) begin
         model_clear();
      end else if (in_valid) begin
         s = beat_sum();
         for (int d = 0; d < 3; d++) begin
            acc_m[d] += s;
            cnt_m[d]++;
            if (in_last || cnt_m[d] == MB_M[d]) begin
               e.dut  = d;
               e.due  = cyc + LVL_M[d];
               e.data = narrow(acc_m[d], OW_M[d], AW_M[d], sb_);
               e.sat  = sb_;
               e.ovr  = !in_last;
               exp_q.push_back(e);
               acc_m[d] = 0;
               cnt_m[d] = 0;
            end
         end
      end
   endtask

   task automatic check_dut(input int d, input logic v, input longint data,
                            input logic o, input logic s);
      int   idx;
      exp_t p;
      idx = -1;
      foreach (exp_q[i]) begin
         if (exp_q[i].dut == d && exp_q[i].due == cyc) idx = i;
      end
      if (v) begin
         p.dut = d; p.due = cyc; p.data = data; p.ovr = o; p.sat = s;
         log_q.push_back(p);
      end
      if (idx >= 0) begin
         chk($sformatf("d%0d out_valid", d), longint'(v), 1);
         chk($sformatf("d%0d out_data", d), data, exp_q[idx].data);
         chk($sformatf("d%0d out_overrun", d), longint'(o), longint'(exp_q[idx].ovr));
         chk($sformatf("d%0d out_sat", d), longint'(s), longint'(exp_q[idx].sat));
         held_m[d] = exp_q[idx].data;
         exp_q.delete(idx);
      end else begin
         chk($sformatf("d%0d idle out_valid", d), longint'(v), 0);
      end
      chk($sformatf("d%0d held out_data", d), data, held_m[d]);
   endtask

   task automatic tick();
      @(posedge clk);
      cyc++;
      if (rst_n) model_edge();
      #1;
      check_dut(0, va, longint'(da), oa, sa);
      check_dut(1, vb, longint'(db), ob, sb);
      check_dut(2, vc, longint'(dc), oc, sc);
   endtask

   task automatic set_all(input int val);
      for (int i = 0; i < 32; i++) in_data[i] = 17'(val);
   endtask

   task automatic beat(input bit v, input bit l, input int val);
      in_valid = v;
      in_last  = l;
      set_all(val);
      tick();
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      in_last  = 1'b0;
      flush    = 1'b0;
      repeat (n) tick();
   endtask

   task automatic expect_pulse(input string tag, input int d, input int c,
                               input longint data, input bit ovr, input bit sat);
      bit found;
      found = 1'b0;
      foreach (log_q[i]) begin
         if (log_q[i].dut == d && log_q[i].due == c) begin
            found = 1'b1;
            chk({tag, " data"}, log_q[i].data, data);
            chk({tag, " overrun"}, longint'(log_q[i].ovr), longint'(ovr));
            chk({tag, " sat"}, longint'(log_q[i].sat), longint'(sat));
         end
      end
      chk({tag, " pulse seen"}, longint'(found), 1);
   endtask

   function automatic int pulses(input int d);
      int n;
      n = 0;
      foreach (log_q[i]) if (log_q[i].dut == d) n++;
      return n;
   endfunction

   int e0, e1, e2;

   initial begin
      n_chk    = 0;
      n_bad    = 0;
      cyc      = 0;
      rst_n    = 1'b0;
      flush    = 1'b0;
      in_valid = 1'b0;
      in_last  = 1'b0;
      set_all(0);
      model_clear();

      repeat (3) tick();
      chk("reset out_valid", longint'(va), 0);
      chk("reset out_data", longint'(da), 0);
      chk("reset out_overrun", longint'(oa), 0);
      rst_n = 1'b1;
      idle(2);

      // single closing beat: 1..8 x4 with element 31 = -8 -> 128
      log_q.delete();
      for (int i = 0; i < 32; i++) in_data[i] = 17'((i % 8) + 1);
      in_data[31] = -17'sd8;
      in_valid = 1'b1;
      in_last  = 1'b1;
      tick();
      e0 = cyc;
      idle(8);
      expect_pulse("t1 r4", 0, e0 + 3, 128, 1'b0, 1'b0);
      expect_pulse("t1 r2", 1, e0 + 5, 128, 1'b0, 1'b0);
      expect_pulse("t1 ow17", 2, e0 + 3, 128, 1'b0, 1'b0);

      // back-to-back closing beats
      log_q.delete();
      beat(1, 1, 1);
      e0 = cyc;
      beat(1, 1, -1);
      beat(1, 1, 2);
      idle(8);
      expect_pulse("t2 b0", 0, e0 + 3, 32, 1'b0, 1'b0);
      expect_pulse("t2 b1", 0, e0 + 4, -32, 1'b0, 1'b0);
      expect_pulse("t2 b2", 0, e0 + 5, 64, 1'b0, 1'b0);

      // 3-beat group with an in_valid gap
      log_q.delete();
      beat(1, 0, 1);
      beat(1, 0, 1);
      beat(0, 0, 7);
      beat(0, 0, 7);
      beat(1, 1, 1);
      e0 = cyc;
      idle(8);
      expect_pulse("t3 gap", 0, e0 + 3, 96, 1'b0, 1'b0);
      chk("t3 pulse count", pulses(0), 1);

      // forced close at MAX_BEATS on dut 1, fifth beat opens a new group
      log_q.delete();
      beat(1, 0, 1);
      beat(1, 0, 1);
      beat(1, 0, 1);
      beat(1, 0, 1);
      e0 = cyc;
      beat(1, 0, 1);
      beat(1, 1, 0);
      e1 = cyc;
      idle(10);
      expect_pulse("t4 overrun", 1, e0 + 5, 128, 1'b1, 1'b0);
      expect_pulse("t4 new group", 1, e1 + 5, 32, 1'b0, 1'b0);
      expect_pulse("t4 long group", 0, e1 + 3, 160, 1'b0, 1'b0);

      // narrowed output with an out-of-range result
      log_q.delete();
      beat(1, 1, 65535);
      e0 = cyc;
      idle(8);
`ifdef ADDER_TREE_ACC_SAT_EN
      expect_pulse("t5 narrow", 2, e0 + 3, 65535, 1'b0, 1'b1);
`else
      expect_pulse("t5 narrow", 2, e0 + 3, -32, 1'b0, 1'b0);
`endif
      expect_pulse("t5 full", 0, e0 + 3, 2097120, 1'b0, 1'b0);

      // async reset in the middle of a group
      log_q.delete();
      beat(1, 0, 1);
      beat(1, 0, 1);
      in_valid = 1'b0;
      rst_n    = 1'b0;
      model_clear();
      #1;
      chk("t6 async out_data", longint'(da), 0);
      chk("t6 async out_valid", longint'(va), 0);
      idle(2);
      rst_n = 1'b1;
      idle(1);
      beat(1, 1, 1);
      e0 = cyc;
      idle(8);
      expect_pulse("t6 after reset", 0, e0 + 3, 32, 1'b0, 1'b0);
      chk("t6 pulse count", pulses(0), 1);

      // flush in the middle of a group, flushed beat discarded
      log_q.delete();
      beat(1, 0, 1);
      beat(1, 0, 1);
      flush = 1'b1;
      beat(1, 0, 1);
      flush = 1'b0;
      beat(1, 1, 1);
      e0 = cyc;
      idle(8);
      expect_pulse("t7 after flush r4", 0, e0 + 3, 32, 1'b0, 1'b0);
      expect_pulse("t7 after flush r2", 1, e0 + 5, 32, 1'b0, 1'b0);
      chk("t7 pulse count", pulses(0), 1);

      // randomized stream
      for (int n = 0; n < 800; n++) begin
         in_valid = ($urandom_range(0, 3) != 0);
         in_last  = ($urandom_range(0, 5) == 0);
         flush    = ($urandom_range(0, 60) == 0);
         if ($urandom_range(0, 3) == 0) begin
            for (int i = 0; i < 32; i++) in_data[i] = 17'($urandom_range(0, 15)) - 17'sd8;
         end else begin
            for (int i = 0; i < 32; i++) in_data[i] = 17'($urandom);
         end
         tick();
      end
      idle(10);
      chk("final queue drained", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
